decoder_3_8_stream: RTL and testbench

Registered 3-to-8 one-hot decoder with a valid/ready streaming interface on both sides. It is the inverse of the team's 8-to-3 priority encoder: it turns a 3-bit index back into a one-hot select line for downstream select/enable fabric. A two-entry skid buffer gives full throughput under backpressure. Sticky coverage and transfer-count status support bring-up and debug.

---
 rtl/decoder_3_8_stream.sv | 111 +++++++++++
 tb/tb_decoder_3_8_stream.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_3_8_stream.sv
// Registered 3-to-8 one-hot decoder with valid/ready on both sides and a
// two-entry skid buffer; sticky coverage and saturating transfer count for debug.
module decoder_3_8_stream #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       in_code,
    input  logic             in_en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       seen,
    input  logic             seen_clr,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] main_q, skid_q;
    logic [7:0] value;
    logic       acc, xfer;

    assign value = in_en ? (8'b1 << in_code) : 8'h00;
    assign acc   = in_valid & in_ready;
    assign xfer  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (acc) state_nxt = ONE;
            ONE: begin
                if (acc && !xfer)      state_nxt = FULL;
                else if (xfer && !acc) state_nxt = EMPTY;
            end
            FULL:  if (xfer) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake flags depend only on the state register, never on in_*/out_ready.
    always_comb begin
        in_ready   = 1'b1;
        out_valid  = 1'b0;
        out_onehot = 8'h00;
        unique case (state)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ONE: begin
                in_ready   = 1'b1;
                out_valid  = 1'b1;
                out_onehot = main_q;
            end
            FULL: begin
                in_ready   = 1'b0;
                out_valid  = 1'b1;
                out_onehot = main_q;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            unique case (state)
                EMPTY: if (acc) main_q <= value;
                ONE: begin
                    if (acc && xfer) main_q <= value;
                    else if (acc)    skid_q <= value;
                end
                FULL:  if (xfer) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    // Clear takes priority, then the coincident transfer is counted on top of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen     <= '0;
            xfer_cnt <= '0;
        end else if (seen_clr) begin
            seen     <= xfer ? out_onehot : 8'h00;
            xfer_cnt <= xfer ? CNT_W'(1) : '0;
        end else if (xfer) begin
            seen <= seen | out_onehot;
            if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decoder_3_8_stream.sv
// Directed bench for decoder_3_8_stream; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_decoder_3_8_stream;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_code;
    logic       in_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_onehot;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] seen;
    logic       seen_clr;
    logic [7:0] xfer_cnt;

    logic       in_ready2;
    logic [7:0] out_onehot2;
    logic       out_valid2;
    logic [7:0] seen2;
    logic [1:0] xfer_cnt2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_oh [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [1:0] exp_c2 [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    decoder_3_8_stream #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_en(in_en),
        .in_valid(in_valid), .in_ready(in_ready), .out_onehot(out_onehot),
        .out_valid(out_valid), .out_ready(out_ready), .seen(seen),
        .seen_clr(seen_clr), .xfer_cnt(xfer_cnt)
    );

    decoder_3_8_stream #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_en(in_en),
        .in_valid(in_valid), .in_ready(in_ready2), .out_onehot(out_onehot2),
        .out_valid(out_valid2), .out_ready(out_ready), .seen(seen2),
        .seen_clr(seen_clr), .xfer_cnt(xfer_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_code   = 3'd0;
        in_en     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        seen_clr  = 1'b0;
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_onehot",    {24'd0, out_onehot}, 32'h00);
        chk("rst_seen",      {24'd0, seen},       32'h00);
        chk("rst_xfer_cnt",  {24'd0, xfer_cnt},   32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Codes 0..7 back to back with downstream always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_en     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_code = 3'(i);
            step();
            chk("stream_valid",  {31'd0, out_valid},  32'd1);
            chk("stream_onehot", {24'd0, out_onehot}, {24'd0, exp_oh[i]});
            chk("stream_cnt",    {24'd0, xfer_cnt},   32'(i));
            if (i >= 1 && i <= 5)
                chk("sat_cnt2", {30'd0, xfer_cnt2}, {30'd0, exp_c2[i]});
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("stream_seen",        {24'd0, seen},      32'hFF);
        chk("stream_cnt_final",   {24'd0, xfer_cnt},  32'd8);
        chk("sat_cnt2_final",     {30'd0, xfer_cnt2}, 32'd3);

        // Disabled decode is still a transfer.
        in_code  = 3'd5;
        in_en    = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("dis_valid",  {31'd0, out_valid},  32'd1);
        chk("dis_onehot", {24'd0, out_onehot}, 32'h00);
        step();
        chk("dis_seen", {24'd0, seen},     32'hFF);
        chk("dis_cnt",  {24'd0, xfer_cnt}, 32'd9);

        // Backpressure: 1,2,3 with out_ready low from the start.
        out_ready = 1'b0;
        in_en     = 1'b1;
        in_valid  = 1'b1;
        in_code   = 3'd1;
        step();
        chk("bp1_onehot",   {24'd0, out_onehot}, 32'h02);
        chk("bp1_in_ready", {31'd0, in_ready},   32'd1);
        in_code = 3'd2;
        step();
        chk("bp2_onehot",   {24'd0, out_onehot}, 32'h02);
        chk("bp2_in_ready", {31'd0, in_ready},   32'd0);
        in_code = 3'd3;
        step();
        chk("bp3_onehot",   {24'd0, out_onehot}, 32'h02);
        chk("bp3_in_ready", {31'd0, in_ready},   32'd0);
        step();
        chk("bp4_valid",    {31'd0, out_valid},  32'd1);
        chk("bp4_onehot",   {24'd0, out_onehot}, 32'h02);
        out_ready = 1'b1;
        step();
        chk("bp_drain1_onehot",   {24'd0, out_onehot}, 32'h04);
        chk("bp_drain1_in_ready", {31'd0, in_ready},   32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_drain2_onehot", {24'd0, out_onehot}, 32'h08);
        step();
        chk("bp_drain3_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_cnt",          {24'd0, xfer_cnt},  32'd12);

        // Clear alone, build seen=0x12, then clear coincident with 0x40.
        out_ready = 1'b0;
        seen_clr  = 1'b1;
        step();
        seen_clr = 1'b0;
        chk("clr_seen", {24'd0, seen},     32'h00);
        chk("clr_cnt",  {24'd0, xfer_cnt}, 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 3'd1;
        step();
        in_code = 3'd4;
        step();
        in_valid = 1'b0;
        step();
        chk("pre_seen", {24'd0, seen},     32'h12);
        chk("pre_cnt",  {24'd0, xfer_cnt}, 32'd2);
        in_valid = 1'b1;
        in_code  = 3'd6;
        step();
        in_valid = 1'b0;
        seen_clr = 1'b1;
        step();
        seen_clr = 1'b0;
        chk("clrx_seen", {24'd0, seen},     32'h40);
        chk("clrx_cnt",  {24'd0, xfer_cnt}, 32'd1);

        // Reset while FULL discards both held items.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 3'd0;
        step();
        in_code = 3'd7;
        step();
        in_valid = 1'b0;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid",    {31'd0, out_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready},  32'd1);
        chk("mrst_onehot",   {24'd0, out_onehot}, 32'h00);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_valid1", {31'd0, out_valid}, 32'd0);
        step();
        chk("post_rst_valid2", {31'd0, out_valid}, 32'd0);
        chk("post_rst_cnt",    {24'd0, xfer_cnt},  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
